// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, scoreboard
// entries and bypass select encodings.
package cpu_ctrl_pkg;

  // Widest register address a scoreboard entry can hold.
  localparam int RF_ADDR_MAX = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic                   valid;
    logic [RF_ADDR_MAX-1:0] dst;
    logic                   we;
    logic                   is_load;
  } sb_entry_t;

  localparam logic [1:0] BYP_RF = 2'd0;
  localparam logic [1:0] BYP_EX = 2'd1;
  localparam logic [1:0] BYP_DM = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority match of one source register against the in-flight scoreboard;
// the youngest (lowest-numbered) matching stage supplies the bypass.
module fwd_match
  import cpu_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W = 4,
  parameter int NUM_FWD   = 2,
  parameter bit ZERO_REG  = 1'b1,
  parameter int BYP_W     = 2
) (
  input  logic [RF_ADDR_W-1:0]    src,
  input  logic                    re,
  input  sb_entry_t [NUM_FWD-1:0] sb,
  output logic [BYP_W-1:0]        sel,
  output logic                    ld_use
);

  logic [NUM_FWD-1:0] hit;
  logic               src_zero;
  logic               unused_sb;

  assign src_zero = ZERO_REG && (src == '0);

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_hit
    assign hit[k] = re & sb[k].valid & sb[k].we & ~src_zero &
                    (sb[k].dst == RF_ADDR_MAX'(src));
  end

  // Walk oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    sel = BYP_W'(BYP_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (hit[k]) sel = BYP_W'(k + 1);
  end

  assign ld_use    = hit[0] & sb[0].is_load;
  assign unused_sb = ^sb;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bypass/squash/halt control for the 5-stage core, driven by
// a scoreboard of destination registers in flight past ID.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int   RF_ADDR_W = 4,
  parameter int   NUM_FWD   = 2,
  parameter bit   ZERO_REG  = 1'b1,
  localparam int  BYP_W     = $clog2(NUM_FWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rdy,
  input  logic                 d_rdy,
  input  logic                 allow_hlt,
  input  logic                 id_valid,
  input  logic [RF_ADDR_W-1:0] id_src0_addr,
  input  logic [RF_ADDR_W-1:0] id_src1_addr,
  input  logic                 id_src0_re,
  input  logic                 id_src1_re,
  input  logic [RF_ADDR_W-1:0] id_dst_addr,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic                 id_hlt,
  input  logic                 flow_change,
  output logic                 stall_IM_ID,
  output logic                 stall_ID_EX,
  output logic                 stall_EX_DM,
  output logic                 stall_DM_WB,
  output logic                 bubble_ID_EX,
  output logic                 flush_IM_ID,
  output logic [BYP_W-1:0]     byp0_sel,
  output logic [BYP_W-1:0]     byp1_sel,
  output logic                 hlt
);

  localparam int CNT_W = $clog2(NUM_FWD + 2);

  ctrl_state_e               state;
  logic [CNT_W-1:0]          drain_cnt;
  sb_entry_t [NUM_FWD-1:0]   sb;
  sb_entry_t                 sb_in;
  logic                      lu0, lu1, load_use, sb_adv;

  fwd_match #(.RF_ADDR_W(RF_ADDR_W), .NUM_FWD(NUM_FWD), .ZERO_REG(ZERO_REG), .BYP_W(BYP_W))
    u_fwd0 (.src(id_src0_addr), .re(id_src0_re), .sb(sb), .sel(byp0_sel), .ld_use(lu0));

  fwd_match #(.RF_ADDR_W(RF_ADDR_W), .NUM_FWD(NUM_FWD), .ZERO_REG(ZERO_REG), .BYP_W(BYP_W))
    u_fwd1 (.src(id_src1_addr), .re(id_src1_re), .sb(sb), .sel(byp1_sel), .ld_use(lu1));

  // A taken branch squashes ID, so a load-use there no longer matters.
  assign load_use = (lu0 | lu1) & ~flow_change;
  assign hlt      = (state == HALTED);

  always_comb begin
    stall_IM_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    stall_DM_WB  = 1'b0;
    bubble_ID_EX = 1'b0;
    flush_IM_ID  = 1'b0;
    if (state == HALTED || !d_rdy) begin
      stall_IM_ID = 1'b1;
      stall_ID_EX = 1'b1;
      stall_EX_DM = 1'b1;
      stall_DM_WB = 1'b1;
    end else begin
      flush_IM_ID = flow_change;
      if (state == DRAIN) begin
        stall_IM_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end else begin
        stall_IM_ID  = ~i_rdy | load_use;
        stall_ID_EX  = load_use;
        bubble_ID_EX = ~i_rdy | load_use | flow_change;
      end
    end
  end

  // A bubble still lets EX move on, so it advances the scoreboard.
  assign sb_adv = ~stall_ID_EX | bubble_ID_EX;

  always_comb begin
    sb_in         = '0;
    sb_in.valid   = id_valid & ~bubble_ID_EX;
    sb_in.dst     = RF_ADDR_MAX'(id_dst_addr);
    sb_in.we      = id_we;
    sb_in.is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (sb_adv) begin
      sb[0] <= sb_in;
      for (int k = 1; k < NUM_FWD; k++) sb[k] <= sb[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: if (id_valid && id_hlt && !flow_change && !stall_ID_EX) begin
          state     <= DRAIN;
          drain_cnt <= CNT_W'(NUM_FWD + 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            if (allow_hlt) state <= HALTED;
          end else if (d_rdy) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl at NUM_FWD = 2 and 3,
// scored against an age-ordered scoreboard model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rdy, d_rdy, allow_hlt, id_valid;
  logic [3:0] id_src0_addr, id_src1_addr, id_dst_addr;
  logic       id_src0_re, id_src1_re, id_we, id_is_load, id_hlt, flow_change;

  logic       stall_IM_ID_a, stall_ID_EX_a, stall_EX_DM_a, stall_DM_WB_a, bubble_a, flush_a, hlt_a;
  logic       stall_IM_ID_b, stall_ID_EX_b, stall_EX_DM_b, stall_DM_WB_b, bubble_b, flush_b, hlt_b;
  logic [1:0] byp0_a, byp1_a, byp0_b, byp1_b;
  logic [14:0] obs_a, obs_b;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RF_ADDR_W(4), .NUM_FWD(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_rdy(i_rdy), .d_rdy(d_rdy), .allow_hlt(allow_hlt),
    .id_valid(id_valid), .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
    .id_src0_re(id_src0_re), .id_src1_re(id_src1_re), .id_dst_addr(id_dst_addr),
    .id_we(id_we), .id_is_load(id_is_load), .id_hlt(id_hlt), .flow_change(flow_change),
    .stall_IM_ID(stall_IM_ID_a), .stall_ID_EX(stall_ID_EX_a), .stall_EX_DM(stall_EX_DM_a),
    .stall_DM_WB(stall_DM_WB_a), .bubble_ID_EX(bubble_a), .flush_IM_ID(flush_a),
    .byp0_sel(byp0_a), .byp1_sel(byp1_a), .hlt(hlt_a));

  pipe_hazard_ctrl #(.RF_ADDR_W(4), .NUM_FWD(3), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_rdy(i_rdy), .d_rdy(d_rdy), .allow_hlt(allow_hlt),
    .id_valid(id_valid), .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
    .id_src0_re(id_src0_re), .id_src1_re(id_src1_re), .id_dst_addr(id_dst_addr),
    .id_we(id_we), .id_is_load(id_is_load), .id_hlt(id_hlt), .flow_change(flow_change),
    .stall_IM_ID(stall_IM_ID_b), .stall_ID_EX(stall_ID_EX_b), .stall_EX_DM(stall_EX_DM_b),
    .stall_DM_WB(stall_DM_WB_b), .bubble_ID_EX(bubble_b), .flush_IM_ID(flush_b),
    .byp0_sel(byp0_b), .byp1_sel(byp1_b), .hlt(hlt_b));

  assign obs_a = {stall_IM_ID_a, stall_ID_EX_a, stall_EX_DM_a, stall_DM_WB_a, bubble_a,
                  flush_a, hlt_a, 2'b00, byp0_a, 2'b00, byp1_a};
  assign obs_b = {stall_IM_ID_b, stall_ID_EX_b, stall_EX_DM_b, stall_DM_WB_b, bubble_b,
                  flush_b, hlt_b, 2'b00, byp0_b, 2'b00, byp1_b};

  // Reference model, index m: 0 -> depth 2, 1 -> depth 3. Slot 0 is the
  // youngest instruction past ID. mode: 0 run, 1 drain, 2 halted.
  bit e_v  [2][4];
  int e_dst[2][4];
  bit e_we [2][4];
  bit e_ld [2][4];
  int mode [2];
  int left [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mode[m] = 0;
      left[m] = 0;
      for (int k = 0; k < 4; k++) begin
        e_v[m][k] = 0; e_dst[m][k] = 0; e_we[m][k] = 0; e_ld[m][k] = 0;
      end
    end
  endfunction

  function automatic bit hit(int m, int k, int src, bit re);
    return re && e_v[m][k] && e_we[m][k] && (e_dst[m][k] == src) && (src != 0);
  endfunction

  function automatic int sel(int m, int src, bit re);
    for (int k = 0; k < m + 2; k++)
      if (hit(m, k, src, re)) return k + 1;
    return 0;
  endfunction

  function automatic logic [14:0] exp_out(int m);
    bit sim = 0, sid = 0, sex = 0, sdw = 0, bub = 0, fl = 0, hl = 0, lu;
    logic [3:0] b0, b1;
    b0 = 4'(sel(m, int'(id_src0_addr), id_src0_re));
    b1 = 4'(sel(m, int'(id_src1_addr), id_src1_re));
    lu = (hit(m, 0, int'(id_src0_addr), id_src0_re) && e_ld[m][0]) ||
         (hit(m, 0, int'(id_src1_addr), id_src1_re) && e_ld[m][0]);
    if (mode[m] == 2) begin
      sim = 1; sid = 1; sex = 1; sdw = 1; hl = 1;
    end else if (!d_rdy) begin
      sim = 1; sid = 1; sex = 1; sdw = 1;
    end else begin
      fl = flow_change;
      if (mode[m] == 1) begin
        sim = 1; bub = 1;
      end else begin
        lu  = lu && !flow_change;
        sim = !i_rdy || lu;
        sid = lu;
        bub = !i_rdy || lu || flow_change;
      end
    end
    return {sim, sid, sex, sdw, bub, fl, hl, b0, b1};
  endfunction

  function automatic void model_step(int m);
    logic [14:0] e;
    e = exp_out(m);
    if (mode[m] == 0) begin
      if (id_valid && id_hlt && !flow_change && !e[13]) begin
        mode[m] = 1;
        left[m] = m + 3;
      end
    end else if (mode[m] == 1) begin
      if (left[m] == 0) begin
        if (allow_hlt) mode[m] = 2;
      end else if (d_rdy) begin
        left[m] = left[m] - 1;
      end
    end
    if (!e[13] || e[10]) begin
      for (int k = m + 1; k >= 1; k--) begin
        e_v[m][k] = e_v[m][k-1]; e_dst[m][k] = e_dst[m][k-1];
        e_we[m][k] = e_we[m][k-1]; e_ld[m][k] = e_ld[m][k-1];
      end
      e_v[m][0]   = id_valid && !e[10];
      e_dst[m][0] = int'(id_dst_addr);
      e_we[m][0]  = id_we;
      e_ld[m][0]  = id_is_load;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Compare both DUTs at the falling edge, then advance the model.
  task automatic tick();
    @(negedge clk);
    chk("cyc_a", 32'(obs_a), 32'(exp_out(0)));
    chk("cyc_b", 32'(obs_b), 32'(exp_out(1)));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic benign();
    id_valid = 0; id_hlt = 0; id_src0_re = 0; id_src1_re = 0;
    id_src0_addr = 0; id_src1_addr = 0; id_dst_addr = 0;
    id_we = 0; id_is_load = 0; i_rdy = 1; d_rdy = 1; flow_change = 0; allow_hlt = 0;
  endtask

  task automatic set_id(input bit v, input int s0, input bit r0, input int s1, input bit r1,
                        input int d, input bit we, input bit ld, input bit h);
    id_valid = v; id_src0_addr = 4'(s0); id_src0_re = r0; id_src1_addr = 4'(s1);
    id_src1_re = r1; id_dst_addr = 4'(d); id_we = we; id_is_load = ld; id_hlt = h;
  endtask

  task automatic do_reset();
    rst_n = 0;
    benign();
    model_reset();
    settle();
    chk("rst_out_a", 32'(obs_a), 32'h0);
    chk("rst_out_b", 32'(obs_b), 32'h0);
    rst_n = 1;
    settle();
    chk("post_rst_a", 32'(obs_a), 32'h0);
  endtask

  task automatic randomize_inputs(input bit allow_h);
    set_id($urandom_range(7) != 0, $urandom_range(7), $urandom_range(1) == 1,
           $urandom_range(7), $urandom_range(1) == 1, $urandom_range(7),
           $urandom_range(1) == 1, $urandom_range(3) == 0,
           allow_h && ($urandom_range(39) == 0));
    i_rdy       = $urandom_range(7) != 0;
    d_rdy       = $urandom_range(7) != 0;
    flow_change = $urandom_range(9) == 0;
    allow_hlt   = $urandom_range(1) == 1;
  endtask

  initial begin
    do_reset();
    tick();

    // Back-to-back dependency: EX forwarding on both ports, no stall.
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
    tick();
    set_id(1, 3, 1, 3, 1, 4, 1, 0, 0);
    settle();
    chk("raw_byp0", 32'(byp0_a), 32'd1);
    chk("raw_byp1", 32'(byp1_a), 32'd1);
    chk("raw_nostall", 32'({stall_IM_ID_a, stall_ID_EX_a}), 32'd0);
    tick();

    // Load-use: one interlock cycle, then DM forwarding; R0 never forwards.
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 1, 6, 1, 0, 0);
    settle();
    chk("lu_stall", 32'({stall_IM_ID_a, stall_ID_EX_a, bubble_a, stall_EX_DM_a}), 32'b1110);
    tick();
    settle();
    chk("lu_byp0_dm", 32'(byp0_a), 32'd2);
    chk("lu_byp1_r0", 32'(byp1_a), 32'd0);
    chk("lu_released", 32'(stall_ID_EX_a), 32'd0);
    tick();

    // Data-cache miss for 5 cycles: full freeze, scoreboard held.
    set_id(1, 6, 1, 6, 1, 7, 1, 0, 0);
    d_rdy = 0;
    settle();
    chk("frz_byp0_before", 32'(byp0_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("frz_stalls", 32'({stall_IM_ID_a, stall_ID_EX_a, stall_EX_DM_a, stall_DM_WB_a, bubble_a}),
          32'b11110);
      tick();
      if (i == 4) d_rdy = 1;
      settle();
    end
    chk("frz_byp0_after", 32'(byp0_a), 32'd1);
    chk("frz_byp1_after", 32'(byp1_a), 32'd1);
    tick();

    // Taken branch squashes a HLT sitting in ID.
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    flow_change = 1;
    settle();
    chk("br_flush_bubble", 32'({flush_a, bubble_a}), 32'b11);
    tick();
    benign();
    settle();
    chk("br_no_drain", 32'({stall_IM_ID_a, hlt_a, stall_IM_ID_b, hlt_b}), 32'd0);
    tick();

    for (int i = 0; i < 250; i++) begin
      randomize_inputs(1'b0);
      tick();
    end

    // HLT with the memory hierarchy busy: drain, wait, then halt.
    benign();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    benign();
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("drain_wait", 32'({stall_IM_ID_a, bubble_a, hlt_a}), 32'b110);
      tick();
    end
    allow_hlt = 1;
    settle();
    chk("hlt_not_yet", 32'(hlt_a), 32'd0);
    tick();
    settle();
    chk("hlt_a_rise", 32'({hlt_a, stall_IM_ID_a, stall_DM_WB_a}), 32'b111);
    chk("hlt_b_rise", 32'(hlt_b), 32'd1);
    for (int i = 0; i < 8; i++) begin
      randomize_inputs(1'b1);
      tick();
    end

    // Drain length with allow_hlt already high: depth 2 halts on the 4th edge.
    do_reset();
    allow_hlt = 1;
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    settle();
    chk("drain3_hlt_a", 32'(hlt_a), 32'd0);
    tick();
    settle();
    chk("drain4_hlt_a", 32'(hlt_a), 32'd1);
    chk("drain4_hlt_b", 32'(hlt_b), 32'd0);
    tick();
    settle();
    chk("drain5_hlt_b", 32'(hlt_b), 32'd1);

    // Reset in the middle of DRAIN returns to RUN with an empty scoreboard.
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    benign();
    tick();
    tick();
    do_reset();
    tick();

    // Third-stage match only exists in the deeper variant.
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    set_id(1, 3, 1, 3, 1, 9, 1, 0, 0);
    settle();
    chk("fwd3_byp0_b", 32'(byp0_b), 32'd3);
    chk("fwd3_byp1_b", 32'(byp1_b), 32'd3);
    chk("fwd3_byp0_a", 32'(byp0_a), 32'd0);
    tick();

    for (int i = 0; i < 250; i++) begin
      randomize_inputs(1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
